// File: rtl/bus_pkg.sv
// Shared definitions for the STM32-side DATA_BUS initiator:
// command codes, payload sizes and controller states.
package bus_pkg;

  localparam logic [2:0] CMD_GET_PARAMS  = 3'd1;
  localparam logic [2:0] CMD_SEND_PARAMS = 3'd2;
  localparam logic [2:0] CMD_TX_IQ       = 3'd3;
  localparam logic [2:0] CMD_RX_IQ       = 3'd4;
  localparam logic [2:0] CMD_AUDIO_ON    = 3'd5;
  localparam logic [2:0] CMD_AUDIO_OFF   = 3'd6;

  localparam logic [3:0] LEN_GET_PARAMS  = 4'd4;
  localparam logic [3:0] LEN_SEND_PARAMS = 4'd4;
  localparam logic [3:0] LEN_TX_IQ       = 4'd4;
  localparam logic [3:0] LEN_RX_IQ       = 4'd8;
  localparam logic [3:0] LEN_AUDIO_ON    = 4'd0;
  localparam logic [3:0] LEN_AUDIO_OFF   = 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WR,
    ST_RD_WAIT,
    ST_RD,
    ST_GAP,
    ST_ERR
  } state_t;

  function automatic logic [3:0] payload_len(
    input logic [2:0] code
  );
    logic [3:0] n;
    case (code)
      CMD_GET_PARAMS:  n = LEN_GET_PARAMS;
      CMD_SEND_PARAMS: n = LEN_SEND_PARAMS;
      CMD_TX_IQ:       n = LEN_TX_IQ;
      CMD_RX_IQ:       n = LEN_RX_IQ;
      CMD_AUDIO_ON:    n = LEN_AUDIO_ON;
      CMD_AUDIO_OFF:   n = LEN_AUDIO_OFF;
      default:         n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic is_write(
    input logic [2:0] code
  );
    return (code == CMD_GET_PARAMS) ||
           (code == CMD_TX_IQ);
  endfunction

  function automatic logic is_read(
    input logic [2:0] code
  );
    return (code == CMD_SEND_PARAMS) ||
           (code == CMD_RX_IQ);
  endfunction

  function automatic logic is_valid(
    input logic [2:0] code
  );
    return (code != 3'd0) && (code != 3'd7);
  endfunction

endpackage

// File: rtl/stm32_bus_rd_shift.sv
// Read-byte capture shift register shared by both read commands.
// First captured byte ends up in the most significant position.
module stm32_bus_rd_shift (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [63:0] data_nxt,
  output logic [2:0]  cnt
);

  logic [63:0] data;

  assign data_nxt = {data[55:0], din};

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
      cnt  <= '0;
    end else if (clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      data <= data_nxt;
      if (cnt != 3'd7) cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/stm32_bus_master.sv
// FPGA-side initiator for the DATA_BUS / DATA_SYNC exchange,
// taking the STM32 role: one command per valid/ready accept.
module stm32_bus_master
  import bus_pkg::*;
#(
  parameter int RD_DELAY   = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_code,
  input  logic        wr_preamp,
  input  logic        wr_tx,
  input  logic [21:0] wr_freq,
  input  logic [15:0] wr_tx_i,
  input  logic [15:0] wr_tx_q,
  output logic        rd_valid,
  output logic        rd_adc_otr,
  output logic        rd_dac_otr,
  output logic [11:0] rd_adc_min,
  output logic [11:0] rd_adc_max,
  output logic [15:0] rd_spec_i,
  output logic [15:0] rd_spec_q,
  output logic [15:0] rd_voice_i,
  output logic [15:0] rd_voice_q,
  output logic        cmd_err,
  output logic        busy,
  output logic        DATA_SYNC,
  inout  wire  [7:0]  DATA_BUS
);

  localparam logic [7:0] RD_LAST  = 8'(RD_DELAY - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam state_t     ST_POST  =
    (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
  localparam state_t     ST_RD1   =
    (RD_DELAY > 0) ? ST_RD_WAIT : ST_RD;

  state_t      state;
  state_t      nstate;
  logic [7:0]  tmr;
  logic [2:0]  code_q;
  logic [31:0] wr_q;
  logic        accept;
  logic        oe;
  logic [7:0]  bus_q;
  logic [63:0] sh_nxt;
  logic [2:0]  sh_cnt;
  logic [2:0]  rd_last;
  logic        publish;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign cmd_err   = (state == ST_ERR);
  assign accept    = cmd_ready && cmd_valid;
  assign rd_last   = 3'(payload_len(code_q) - 4'd1);
  assign publish   = (state == ST_RD) && (sh_cnt == rd_last);
  assign DATA_BUS  = oe ? bus_q : 8'hzz;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      tmr    <= '0;
      code_q <= '0;
      wr_q   <= '0;
    end else begin
      state <= nstate;
      tmr   <= (nstate != state) ? 8'd0 : tmr + 8'd1;
      if (accept) begin
        code_q <= cmd_code;
        wr_q   <= (cmd_code == CMD_TX_IQ) ?
                  {wr_tx_q, wr_tx_i} :
                  {4'b0, wr_tx, wr_preamp, 2'b0,
                   2'b0, wr_freq};
      end else if (state == ST_WR) begin
        wr_q <= {wr_q[23:0], 8'h00};
      end
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE:
        if (cmd_valid)
          nstate = is_valid(cmd_code) ? ST_SYNC : ST_ERR;
      ST_ERR:
        nstate = ST_IDLE;
      ST_SYNC:
        if (is_write(code_q))     nstate = ST_WR;
        else if (is_read(code_q)) nstate = ST_RD1;
        else                      nstate = ST_POST;
      ST_WR:
        if (tmr == 8'd3) nstate = ST_POST;
      ST_RD_WAIT:
        if (tmr == RD_LAST) nstate = ST_RD;
      ST_RD:
        if (publish) nstate = ST_POST;
      ST_GAP:
        if (tmr == GAP_LAST) nstate = ST_IDLE;
      default:
        nstate = ST_IDLE;
    endcase
  end

  // Bus is only driven in SYNC and WR; everything else releases it.
  always_comb begin
    DATA_SYNC = 1'b0;
    oe        = 1'b0;
    bus_q     = 8'h00;
    unique case (1'b1)
      (state == ST_SYNC): begin
        DATA_SYNC = 1'b1;
        oe        = 1'b1;
        bus_q     = {5'b0, code_q};
      end
      (state == ST_WR): begin
        oe    = 1'b1;
        bus_q = wr_q[31:24];
      end
      default: ;
    endcase
  end

  stm32_bus_rd_shift u_rd_shift (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .clr      (state == ST_SYNC),
    .load     (state == ST_RD),
    .din      (DATA_BUS),
    .data_nxt (sh_nxt),
    .cnt      (sh_cnt)
  );

  // Outputs load straight from the shift path so they appear
  // together with rd_valid right after the final capture.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid   <= 1'b0;
      rd_adc_otr <= 1'b0;
      rd_dac_otr <= 1'b0;
      rd_adc_min <= '0;
      rd_adc_max <= '0;
      rd_spec_i  <= '0;
      rd_spec_q  <= '0;
      rd_voice_i <= '0;
      rd_voice_q <= '0;
    end else begin
      rd_valid <= publish;
      if (publish && code_q == CMD_SEND_PARAMS) begin
        rd_dac_otr <= sh_nxt[25];
        rd_adc_otr <= sh_nxt[24];
        rd_adc_min <= {sh_nxt[23:20], sh_nxt[15:8]};
        rd_adc_max <= {sh_nxt[19:16], sh_nxt[7:0]};
      end
      if (publish && code_q == CMD_RX_IQ) begin
        rd_spec_q  <= sh_nxt[63:48];
        rd_spec_i  <= sh_nxt[47:32];
        rd_voice_q <= sh_nxt[31:16];
        rd_voice_i <= sh_nxt[15:0];
      end
    end
  end

endmodule

// File: tb/tb_stm32_bus_master.sv
// Randomized bench for stm32_bus_master with a bus responder
// and a byte-level reference model of the exchange.
module tb_stm32_bus_master;

  localparam int RDD = 1;
  localparam int GAP = 2;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_code = 3'd0;
  logic        wr_preamp = 1'b0;
  logic        wr_tx = 1'b0;
  logic [21:0] wr_freq = '0;
  logic [15:0] wr_tx_i = '0;
  logic [15:0] wr_tx_q = '0;
  logic        rd_valid;
  logic        rd_adc_otr;
  logic        rd_dac_otr;
  logic [11:0] rd_adc_min;
  logic [11:0] rd_adc_max;
  logic [15:0] rd_spec_i;
  logic [15:0] rd_spec_q;
  logic [15:0] rd_voice_i;
  logic [15:0] rd_voice_q;
  logic        cmd_err;
  logic        busy;
  logic        DATA_SYNC;
  wire  [7:0]  DATA_BUS;

  logic        r_oe = 1'b0;
  logic [7:0]  r_dat = 8'h00;
  logic [7:0]  resp_q[$];
  int          rk = 0;
  int          rn = 4;
  bit          seen = 1'b0;

  int errs = 0;
  int checks = 0;

  logic        m_dac, m_adc;
  logic [11:0] m_min, m_max;
  logic [15:0] m_si, m_sq, m_vi, m_vq;

  assign DATA_BUS = r_oe ? r_dat : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (DATA_BUS[g]);
  end

  always #5 clk_in = ~clk_in;

  stm32_bus_master #(
    .RD_DELAY   (RDD),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .wr_preamp  (wr_preamp),
    .wr_tx      (wr_tx),
    .wr_freq    (wr_freq),
    .wr_tx_i    (wr_tx_i),
    .wr_tx_q    (wr_tx_q),
    .rd_valid   (rd_valid),
    .rd_adc_otr (rd_adc_otr),
    .rd_dac_otr (rd_dac_otr),
    .rd_adc_min (rd_adc_min),
    .rd_adc_max (rd_adc_max),
    .rd_spec_i  (rd_spec_i),
    .rd_spec_q  (rd_spec_q),
    .rd_voice_i (rd_voice_i),
    .rd_voice_q (rd_voice_q),
    .cmd_err    (cmd_err),
    .busy       (busy),
    .DATA_SYNC  (DATA_SYNC),
    .DATA_BUS   (DATA_BUS)
  );

  // Responder: registered output, byte i valid in cycle S+2+i.
  initial begin
    forever begin
      @(negedge clk_in);
      seen = (DATA_SYNC === 1'b1) &&
             (DATA_BUS == 8'd2 || DATA_BUS == 8'd4);
      if (seen) rn = (DATA_BUS == 8'd2) ? 4 : 8;
      @(posedge clk_in);
      #1;
      if (!reset_n) begin
        rk = 0;
        r_oe = 1'b0;
      end else begin
        if (seen) rk = 1;
        else if (rk > 0) rk++;
        if (rk >= 2 && rk < 2 + rn) begin
          r_oe = 1'b1;
          r_dat = resp_q[rk-2];
        end else begin
          r_oe = 1'b0;
          if (rk >= 2 + rn) rk = 0;
        end
      end
    end
  end

  always @(negedge reset_n) begin
    r_oe = 1'b0;
    rk = 0;
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [89:0] rd_pack();
    return {rd_dac_otr, rd_adc_otr, rd_adc_min, rd_adc_max,
            rd_spec_i, rd_spec_q, rd_voice_i, rd_voice_q};
  endfunction

  function automatic logic [89:0] m_pack();
    return {m_dac, m_adc, m_min, m_max,
            m_si, m_sq, m_vi, m_vq};
  endfunction

  task automatic m_clear();
    m_dac = 0; m_adc = 0; m_min = 0; m_max = 0;
    m_si = 0; m_sq = 0; m_vi = 0; m_vq = 0;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk_in);
      w++;
    end
    chk("ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic scramble_inputs();
    wr_preamp = 1'($urandom);
    wr_tx     = 1'($urandom);
    wr_freq   = 22'($urandom);
    wr_tx_i   = 16'($urandom);
    wr_tx_q   = 16'($urandom);
  endtask

  task automatic run_cmd(input logic [2:0] code,
                         input logic pre, input logic tx,
                         input logic [21:0] freq,
                         input logic [15:0] ti,
                         input logic [15:0] tq,
                         input bit hold,
                         input logic [2:0] nxt);
    logic [7:0]  wq[4];
    logic [7:0]  eb;
    logic [89:0] old_rd, new_rd;
    bit iswr, isrd, bad;
    int n, len, ncyc;
    iswr = (code == 3'd1 || code == 3'd3);
    isrd = (code == 3'd2 || code == 3'd4);
    bad  = (code == 3'd0 || code == 3'd7);
    n    = (code == 3'd4) ? 8 : 4;
    if (code == 3'd1) begin
      wq[0] = 8'(int'(tx) * 8 + int'(pre) * 4);
      wq[1] = 8'(int'(freq) / 65536);
      wq[2] = 8'((int'(freq) / 256) % 256);
      wq[3] = 8'(int'(freq) % 256);
    end else begin
      wq[0] = 8'(int'(tq) / 256);
      wq[1] = 8'(int'(tq) % 256);
      wq[2] = 8'(int'(ti) / 256);
      wq[3] = 8'(int'(ti) % 256);
    end
    old_rd = m_pack();
    if (code == 3'd2) begin
      m_dac = resp_q[0][1];
      m_adc = resp_q[0][0];
      m_min = 12'(int'(resp_q[1]) / 16 * 256 + int'(resp_q[2]));
      m_max = 12'(int'(resp_q[1]) % 16 * 256 + int'(resp_q[3]));
    end else if (code == 3'd4) begin
      m_sq = 16'(int'(resp_q[0]) * 256 + int'(resp_q[1]));
      m_si = 16'(int'(resp_q[2]) * 256 + int'(resp_q[3]));
      m_vq = 16'(int'(resp_q[4]) * 256 + int'(resp_q[5]));
      m_vi = 16'(int'(resp_q[6]) * 256 + int'(resp_q[7]));
    end
    new_rd = m_pack();
    if (bad) len = 1;
    else if (iswr) len = 5;
    else if (isrd) len = 1 + RDD + n;
    else len = 1;
    ncyc = bad ? 1 : len + GAP;

    wait_ready();
    cmd_valid = 1'b1;
    cmd_code  = code;
    wr_preamp = pre;
    wr_tx     = tx;
    wr_freq   = freq;
    wr_tx_i   = ti;
    wr_tx_q   = tq;
    @(posedge clk_in);
    @(negedge clk_in);
    if (hold) cmd_code = nxt;
    else begin
      cmd_valid = 1'b0;
      cmd_code  = 3'($urandom);
    end
    scramble_inputs();

    for (int c = 0; c < ncyc; c++) begin
      if (bad) eb = 8'hFF;
      else if (c == 0) eb = {5'b0, code};
      else if (iswr && c <= 4) eb = wq[c-1];
      else if (isrd && c > RDD && c <= RDD + n)
        eb = resp_q[c-1-RDD];
      else eb = 8'hFF;
      chk("sync", DATA_SYNC, !bad && c == 0);
      chk("bus", DATA_BUS, eb);
      chk("rd_valid", rd_valid, isrd && c == len);
      chk("rd_out", rd_pack(),
          (isrd && c >= len) ? new_rd : old_rd);
      chk("cmd_err", cmd_err, bad);
      chk("ready", cmd_ready, 1'b0);
      chk("busy", busy, 1'b1);
      @(negedge clk_in);
    end
    chk("idle", {cmd_ready, busy, DATA_SYNC, rd_valid, cmd_err},
        5'b10000);
    chk("idle_bus", DATA_BUS, 8'hFF);
    chk("idle_rd", rd_pack(), new_rd);
  endtask

  task automatic abort_at(input logic [2:0] code, input int at,
                          input logic [7:0] exp_pre);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_code  = code;
    wr_preamp = 1'b1;
    wr_tx     = 1'b0;
    wr_freq   = 22'h0975F7;
    @(posedge clk_in);
    @(negedge clk_in);
    cmd_valid = 1'b0;
    repeat (at) @(negedge clk_in);
    chk("pre_rst_bus", DATA_BUS, exp_pre);
    reset_n = 1'b0;
    #1;
    chk("rst_sync", DATA_SYNC, 1'b0);
    chk("rst_bus", DATA_BUS, 8'hFF);
    chk("rst_state", {cmd_ready, busy, rd_valid}, 3'b100);
    m_clear();
    chk("rst_rd", rd_pack(), m_pack());
    @(negedge clk_in);
    @(negedge clk_in);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_in);
      chk("rst_quiet", {rd_valid, DATA_SYNC}, 2'b00);
      chk("rst_rd_hold", rd_pack(), m_pack());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_clear();
    #1 reset_n = 1'b0;
    #2;
    chk("rst_sync0", DATA_SYNC, 1'b0);
    chk("rst_bus0", DATA_BUS, 8'hFF);
    chk("rst_flags0", {cmd_ready, busy, rd_valid, cmd_err},
        4'b1000);
    chk("rst_rd0", rd_pack(), m_pack());
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);

    run_cmd(3'd1, 1'b1, 1'b0, 22'h0975F7, 16'h0, 16'h0,
            1'b0, 3'd0);
    run_cmd(3'd3, 1'b0, 1'b0, 22'h0, 16'h8001, 16'h7FFE,
            1'b0, 3'd0);

    resp_q = '{8'h03, 8'h8A, 8'h12, 8'h34};
    run_cmd(3'd2, 1'b0, 1'b0, 22'h0, 16'h0, 16'h0,
            1'b0, 3'd0);
    chk("send_otr", {rd_dac_otr, rd_adc_otr}, 2'b11);
    chk("send_min", rd_adc_min, 12'h812);
    chk("send_max", rd_adc_max, 12'hA34);

    resp_q = '{8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88};
    run_cmd(3'd4, 1'b0, 1'b0, 22'h0, 16'h0, 16'h0,
            1'b0, 3'd0);
    chk("rx_sq", rd_spec_q, 16'h1122);
    chk("rx_si", rd_spec_i, 16'h3344);
    chk("rx_vq", rd_voice_q, 16'h5566);
    chk("rx_vi", rd_voice_i, 16'h7788);

    run_cmd(3'd7, 1'b0, 1'b0, 22'h0, 16'h0, 16'h0,
            1'b1, 3'd5);
    run_cmd(3'd5, 1'b0, 1'b0, 22'h0, 16'h0, 16'h0,
            1'b0, 3'd0);

    abort_at(3'd1, 2, 8'h09);
    resp_q = '{8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88};
    abort_at(3'd4, 3, 8'h22);
    run_cmd(3'd1, 1'b0, 1'b1, 22'h3FFFFF, 16'h0, 16'h0,
            1'b0, 3'd0);

    for (int t = 0; t < 40; t++) begin
      resp_q.delete();
      for (int i = 0; i < 8; i++)
        resp_q.push_back(8'($urandom));
      run_cmd(3'($urandom_range(0, 7)), 1'($urandom),
              1'($urandom), 22'($urandom), 16'($urandom),
              16'($urandom), 1'b0, 3'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
